// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory stage.
package dm_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned TAG_W  = 5;
  // Wide enough for any LATENCY in 1..15.
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OP_LD = 1'b0,
    OP_ST = 1'b1
  } op_e;

  // Everything about an accepted request except its word index, whose width
  // depends on the RAM depth of the instance.
  typedef struct packed {
    op_e               op;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] data;
  } req_t;

  // A byte address is usable when it is word aligned and no bit above the
  // word-index field is set, so it can never alias onto a lower word.
  function automatic logic addr_ok(input logic [WORD_W-1:0] ea,
                                   input int unsigned       idx_w);
    return (ea[1:0] == 2'b00) && ((ea >> (idx_w + 2)) == '0);
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port word RAM: synchronous write, synchronous registered read.
// The read register only updates on a read, so it holds the last value read.
module sp_ram
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = WORD_W,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array write port.
  // NOTE: the array has no reset; contents survive reset and the array maps
  // onto a RAM macro, which cannot be cleared in one cycle anyway.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Registered read port; cleared on reset, otherwise holds the last read.
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: accepts one load or store at a time, runs it against the
// internal RAM over a fixed latency and returns load data with its rd tag.
module data_mem_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lw,
  input  logic              sw,
  input  logic [WORD_W-1:0] effective_value,
  input  logic [WORD_W-1:0] data_out_dm,
  input  logic [TAG_W-1:0]  read_data_addr_dm,
  output logic [WORD_W-1:0] write_data_dm,
  output logic [TAG_W-1:0]  wb_rd,
  output logic              wb_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  req_t              req_q, req_d;
  logic [TAG_W-1:0]  wb_rd_q, wb_rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic              err_q, err_d;

  logic              ram_en;
  logic              ram_we;
  logic              one_op;
  logic              addr_valid;

  // Exactly one strobe is a request; both at once is a conflict.
  assign one_op     = lw ^ sw;
  assign addr_valid = addr_ok(effective_value, IDX_W);

  // Next-state, counter and completion control.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    req_d      = req_q;
    wb_rd_d    = wb_rd_q;
    wb_valid_d = 1'b0;
    err_d      = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (one_op && addr_valid) begin
          idx_d    = effective_value[IDX_W+1:2];
          req_d    = '{op:   (sw ? OP_ST : OP_LD),
                       tag:  read_data_addr_dm,
                       data: data_out_dm};
          cnt_d    = CNT_W'(LATENCY - 1);
          state_d  = WAIT;
        end else if (lw || sw) begin
          // Conflicting strobes or an unusable address: pulse err only.
          err_d = 1'b1;
        end
      end

      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Final edge of the transaction: the RAM performs the access and
          // its read register becomes the new write_data_dm for loads.
          ram_en  = 1'b1;
          ram_we  = (req_q.op == OP_ST);
          state_d = IDLE;
          if (req_q.op == OP_LD) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = req_q.tag;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // A reset on the completion edge aborts the access: nothing is written.
    if (reset) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  // State and pipeline registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      req_q      <= '0;
      wb_rd_q    <= '0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      req_q      <= req_d;
      wb_rd_q    <= wb_rd_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
    end
  end

  sp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_sp_ram (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (req_q.data),
    .rdata (write_data_dm)
  );

  assign busy     = (state_q == WAIT);
  assign wb_rd    = wb_rd_q;
  assign wb_valid = wb_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (DEPTH 256 / LATENCY 2 and
// DEPTH 16 / LATENCY 1) share one stimulus stream and are compared every cycle
// against a transaction-level model, plus directed checks with fixed values.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        lw;
  logic        sw;
  logic [31:0] ea;
  logic [31:0] din;
  logic [4:0]  tag;

  logic [31:0] wd0, wd1;
  logic [4:0]  rd0, rd1;
  logic        v0, v1, busy0, busy1, err0, err1;

  int          n_checks = 0;
  int          n_errors = 0;
  longint      cyc      = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(256), .LATENCY(2)) u_dut0 (
    .clk               (clk),
    .reset             (reset),
    .lw                (lw),
    .sw                (sw),
    .effective_value   (ea),
    .data_out_dm       (din),
    .read_data_addr_dm (tag),
    .write_data_dm     (wd0),
    .wb_rd             (rd0),
    .wb_valid          (v0),
    .busy              (busy0),
    .err               (err0)
  );

  data_mem_ctrl #(.DEPTH(16), .LATENCY(1)) u_dut1 (
    .clk               (clk),
    .reset             (reset),
    .lw                (lw),
    .sw                (sw),
    .effective_value   (ea),
    .data_out_dm       (din),
    .read_data_addr_dm (tag),
    .write_data_dm     (wd1),
    .wb_rd             (rd1),
    .wb_valid          (v1),
    .busy              (busy1),
    .err               (err1)
  );

  // ---------------- reference model (per instance k) ----------------
  int          lat   [2] = '{2, 1};
  int          depth [2] = '{256, 16};

  bit          m_pend [2];
  longint      m_done [2];
  bit          m_st   [2];
  int          m_idx  [2];
  logic [31:0] m_data [2];
  logic [4:0]  m_tag  [2];
  logic [31:0] m_mem  [2][256];
  bit          m_known[2][256];

  logic [31:0] e_wd      [2];
  bit          e_wd_known[2];
  logic [4:0]  e_rd      [2];
  bit          e_wbv     [2];
  bit          e_err     [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic bit addr_ok(input int k, input logic [31:0] a);
    logic [1:0] low;
    low = a[1:0];
    return (low == 2'b00) && (longint'(a) < longint'(4 * depth[k]));
  endfunction

  // One clock edge of the specified behaviour, using the inputs applied to it.
  task automatic model_step(input int k);
    if (reset) begin
      m_pend[k]     = 1'b0;
      e_wd[k]       = 32'h0;
      e_wd_known[k] = 1'b1;
      e_rd[k]       = 5'h0;
      e_wbv[k]      = 1'b0;
      e_err[k]      = 1'b0;
      return;
    end
    e_wbv[k] = 1'b0;
    e_err[k] = 1'b0;
    if (m_pend[k]) begin
      if (cyc == m_done[k]) begin
        m_pend[k] = 1'b0;
        if (m_st[k]) begin
          m_mem[k][m_idx[k]]   = m_data[k];
          m_known[k][m_idx[k]] = 1'b1;
        end else begin
          e_wd[k]       = m_mem[k][m_idx[k]];
          e_wd_known[k] = m_known[k][m_idx[k]];
          e_rd[k]       = m_tag[k];
          e_wbv[k]      = 1'b1;
        end
      end
    end else if ((lw ^ sw) && addr_ok(k, ea)) begin
      m_pend[k] = 1'b1;
      m_done[k] = cyc + lat[k];
      m_st[k]   = sw;
      m_idx[k]  = int'(ea >> 2);
      m_data[k] = din;
      m_tag[k]  = tag;
    end else if (lw || sw) begin
      e_err[k] = 1'b1;
    end
  endtask

  task automatic check_dut(input int k, input logic [31:0] wd, input logic [4:0] rd,
                           input logic v, input logic b, input logic e);
    check($sformatf("c%0d d%0d wb_valid", cyc, k), 32'(v), 32'(e_wbv[k]));
    check($sformatf("c%0d d%0d busy", cyc, k), 32'(b), 32'(m_pend[k]));
    check($sformatf("c%0d d%0d err", cyc, k), 32'(e), 32'(e_err[k]));
    check($sformatf("c%0d d%0d wb_rd", cyc, k), 32'(rd), 32'(e_rd[k]));
    if (e_wd_known[k]) check($sformatf("c%0d d%0d write_data_dm", cyc, k), wd, e_wd[k]);
  endtask

  // Apply the current inputs to one edge, then compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    @(negedge clk);
    check_dut(0, wd0, rd0, v0, busy0, err0);
    check_dut(1, wd1, rd1, v1, busy1, err1);
  endtask

  task automatic drive(input bit r, input bit l, input bit s, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] t);
    reset = r; lw = l; sw = s; ea = a; din = d; tag = t;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b1, a, d, 5'h0);
    idle(3);
  endtask

  initial begin
    logic [31:0] a;
    int          r;

    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    check("reset write_data_dm", wd0, 32'h0);
    check("reset busy", 32'(busy0), 32'h0);
    idle(2);

    // Store then load back the same word.
    store(32'h10, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
    check("load busy at T+1", 32'(busy0), 32'h1);
    idle(1);
    check("lat1 wb_valid", 32'(v1), 32'h1);
    check("lat1 load data", wd1, 32'hDEADBEEF);
    check("lat1 wb_rd", 32'(rd1), 32'd5);
    idle(1);
    check("lat2 wb_valid", 32'(v0), 32'h1);
    check("lat2 load data", wd0, 32'hDEADBEEF);
    check("lat2 wb_rd", 32'(rd0), 32'd5);
    idle(2);

    // Misaligned load is rejected.
    drive(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 5'd3);
    check("misaligned err", 32'(err0), 32'h1);
    check("misaligned busy", 32'(busy0), 32'h0);
    idle(1);
    check("err one cycle", 32'(err0), 32'h0);
    idle(1);

    // Out-of-range store must not alias onto word 0.
    store(32'h0, 32'hA5A50000);
    store(32'h4, 32'h55550004);
    drive(1'b0, 1'b0, 1'b1, 32'h400, 32'h12345678, 5'h0);
    check("out of range err", 32'(err0), 32'h1);
    check("out of range err lat1", 32'(err1), 32'h1);
    idle(1);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd1);
    idle(2);
    check("no alias write", wd0, 32'hA5A50000);
    idle(1);

    // Store strobe while busy is ignored.
    store(32'h8, 32'h11111111);
    drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 5'd7);
    drive(1'b0, 1'b0, 1'b1, 32'h8, 32'h22222222, 5'h0);
    check("busy strobe no err", 32'(err0), 32'h0);
    idle(1);
    check("busy store ignored", wd0, 32'h11111111);
    idle(1);
    drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 5'd8);
    idle(3);

    // Reset during a store aborts it.
    store(32'h20, 32'h00004444);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h00003333, 5'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    check("abort wd", wd0, 32'h0);
    check("abort busy", 32'(busy0), 32'h0);
    check("abort wb_valid", 32'(v0), 32'h0);
    check("abort busy lat1", 32'(busy1), 32'h0);
    idle(1);
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 5'd2);
    idle(2);
    check("aborted store not written", wd0, 32'h00004444);
    idle(1);

    // Back-to-back loads on the LATENCY=1 instance.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd9);
    idle(1);
    check("b2b first valid", 32'(v1), 32'h1);
    check("b2b first data", wd1, 32'hA5A50000);
    drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 5'd10);
    check("b2b gap", 32'(v1), 32'h0);
    idle(1);
    check("b2b second valid", 32'(v1), 32'h1);
    check("b2b second data", wd1, 32'h55550004);
    check("b2b second tag", 32'(rd1), 32'd10);
    idle(3);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(9, 0));
      if (r <= 6)      a = 32'($urandom_range(15, 0)) << 2;
      else if (r == 7) a = 32'($urandom_range(255, 16)) << 2;
      else if (r == 8) a = (32'($urandom_range(255, 0)) << 2) | 32'($urandom_range(3, 1));
      else             a = $urandom;
      drive(($urandom_range(49, 0) == 0), ($urandom_range(2, 0) == 0),
            ($urandom_range(2, 0) == 0), a, $urandom, 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
